// File: rtl/bsg_downstream_in_assembler.sv
// BSG link receive side: rebuilds 64-bit words from 4 two-channel beats, buffers
// them in a credit-sized show-ahead FIFO and returns one token per word consumed.
module bsg_downstream_in_assembler #(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned PTR_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_valid_in,
    input  logic [7:0]  io_data_in_ch0,
    input  logic [7:0]  io_data_in_ch1,
    output logic        io_token,
    output logic        core_valid_out,
    output logic [63:0] core_data_out,
    input  logic        core_ready_in,
    output logic        overflow_o,
    output logic [1:0]  step_o
);

    typedef enum logic [1:0] {S0, S1, S2, S3} step_e;

    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    step_e             state, state_nxt;
    logic [63:0]       asm_q;
    logic [63:0]       word_full;
    logic [63:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic              beat_last, full, deq, enq;

    // Step state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S0;
        else      state <= state_nxt;
    end

    // Step next-state logic: advance only on a valid beat
    always_comb begin
        state_nxt = state;
        if (io_valid_in) begin
            case (state)
                S0:      state_nxt = S1;
                S1:      state_nxt = S2;
                S2:      state_nxt = S3;
                default: state_nxt = S0;
            endcase
        end
    end

    // Step outputs
    always_comb begin
        step_o    = state;
        beat_last = io_valid_in && (state == S3);
    end

    // Partial word; bytes of the final beat are merged combinationally into the write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_q <= '0;
        end else if (io_valid_in) begin
            case (state)
                S0: begin asm_q[7:0]   <= io_data_in_ch0; asm_q[23:16] <= io_data_in_ch1; end
                S1: begin asm_q[15:8]  <= io_data_in_ch0; asm_q[31:24] <= io_data_in_ch1; end
                S2: begin asm_q[39:32] <= io_data_in_ch0; asm_q[55:48] <= io_data_in_ch1; end
                default: ;
            endcase
        end
    end

    always_comb begin
        word_full = {io_data_in_ch1, asm_q[55:48], io_data_in_ch0, asm_q[39:0]};
        full      = (count == CNT_FULL);
        deq       = (count != '0) && core_ready_in;
        // A full FIFO still accepts the word when the head leaves on the same edge
        enq       = beat_last && (!full || deq);
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= word_full;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            io_token   <= 1'b0;
        end else begin
            io_token <= deq;
            if (enq) wr_ptr <= wr_ptr + PTR_ONE;
            if (deq) rd_ptr <= rd_ptr + PTR_ONE;
            case ({enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (beat_last && full && !deq) overflow_o <= 1'b1;
        end
    end

    always_comb begin
        core_valid_out = (count != '0);
        core_data_out  = mem[rd_ptr];
    end

endmodule
